// File: rtl/hbm_cmd_arbiter.sv
// Round-robin arbiter sharing one HBM pseudo-channel AXI command port between
// NUM_REQ requesters, gated by calibration and capped at MAX_OUTST in flight.
module hbm_cmd_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ADDR_W    = 33,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned MAX_OUTST = 8
) (
    input  logic                        CLK100,
    input  logic                        RST100,
    input  logic                        hbm_cal_done,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic                        cmd_write,
    output logic [ADDR_W-1:0]           cmd_addr,
    output logic [LEN_W-1:0]            cmd_len,
    output logic [2:0]                  cmd_id,
    input  logic                        cpl_valid,
    output logic [3:0]                  outst_cnt,
    output logic                        busy,
    output logic                        err_underflow
);

    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_WAIT_CAL = 2'd0;
    localparam logic [1:0] S_IDLE     = 2'd1;
    localparam logic [1:0] S_ISSUE    = 2'd2;

    logic [1:0]         state, state_nxt;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [NUM_REQ-1:0] rot;
    logic               found;
    logic [ID_W:0]      wsum;
    logic [ID_W-1:0]    winner;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic               accept;
    logic               grant_fire;

    logic               cmd_valid_nxt;
    logic               cmd_write_nxt;
    logic [ADDR_W-1:0]  cmd_addr_nxt;
    logic [LEN_W-1:0]   cmd_len_nxt;
    logic [ID_W-1:0]    cmd_id_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               err_nxt;
    logic               busy_nxt;

    assign accept = cmd_valid && cmd_ready;

    // Rotate valids so bit 0 is rr_ptr, take the lowest set bit, map back.
    always_comb begin : rr_scan
        rot   = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        found = 1'b0;
        wsum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                wsum  = {1'b0, rr_ptr} + (ID_W+1)'(k);
            end
        end
        if (wsum >= (ID_W+1)'(NUM_REQ)) begin
            wsum = wsum - (ID_W+1)'(NUM_REQ);
        end
        winner    = wsum[ID_W-1:0];
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_len   = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin : fsm_next
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_fire    = 1'b0;
        cmd_valid_nxt = cmd_valid;
        cmd_write_nxt = cmd_write;
        cmd_addr_nxt  = cmd_addr;
        cmd_len_nxt   = cmd_len;
        cmd_id_nxt    = cmd_id;
        cnt_nxt       = outst_cnt;
        err_nxt       = err_underflow;
        req_ready     = '0;

        case (state)
            S_WAIT_CAL: begin
                if (hbm_cal_done) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!hbm_cal_done) begin
                    state_nxt = S_WAIT_CAL;
                end else if (found && (outst_cnt < CNT_W'(MAX_OUTST))) begin
                    grant_fire    = 1'b1;
                    state_nxt     = S_ISSUE;
                    cmd_valid_nxt = 1'b1;
                    cmd_write_nxt = sel_write;
                    cmd_addr_nxt  = sel_addr;
                    cmd_len_nxt   = sel_len;
                    cmd_id_nxt    = winner;
                    rr_ptr_nxt    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    cmd_valid_nxt = 1'b0;
                    state_nxt     = hbm_cal_done ? S_IDLE : S_WAIT_CAL;
                end
            end
            default: begin
                state_nxt     = S_WAIT_CAL;
                cmd_valid_nxt = 1'b0;
            end
        endcase

        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_fire && (winner == ID_W'(i));
        end

        // An accept and a completion in the same cycle cancel out.
        case ({accept, cpl_valid})
            2'b10: cnt_nxt = outst_cnt + CNT_W'(1);
            2'b01: begin
                if (outst_cnt == '0) err_nxt = 1'b1;
                else                 cnt_nxt = outst_cnt - CNT_W'(1);
            end
            default: ;
        endcase

        busy_nxt = (cnt_nxt != '0) || cmd_valid_nxt;
    end

    always_ff @(posedge CLK100 or posedge RST100) begin : fsm_reg
        if (RST100) state <= S_WAIT_CAL;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK100 or posedge RST100) begin : out_reg
        if (RST100) begin
            rr_ptr        <= '0;
            cmd_valid     <= 1'b0;
            cmd_write     <= 1'b0;
            cmd_addr      <= '0;
            cmd_len       <= '0;
            cmd_id        <= '0;
            outst_cnt     <= '0;
            busy          <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            rr_ptr        <= rr_ptr_nxt;
            cmd_valid     <= cmd_valid_nxt;
            cmd_write     <= cmd_write_nxt;
            cmd_addr      <= cmd_addr_nxt;
            cmd_len       <= cmd_len_nxt;
            cmd_id        <= cmd_id_nxt;
            outst_cnt     <= cnt_nxt;
            busy          <= busy_nxt;
            err_underflow <= err_nxt;
        end
    end

endmodule

// File: tb/tb_hbm_cmd_arbiter.sv
// Bench for hbm_cmd_arbiter: directed steps plus random traffic, every cycle
// compared against a transaction-level model of grants and in-flight count.
module tb_hbm_cmd_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned ADDR_W    = 33;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned MAX_OUTST = 8;

    logic                        CLK100 = 1'b0;
    logic                        RST100;
    logic                        hbm_cal_done;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          req_write;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*LEN_W-1:0]    req_len;
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_write;
    logic [ADDR_W-1:0]           cmd_addr;
    logic [LEN_W-1:0]            cmd_len;
    logic [2:0]                  cmd_id;
    logic                        cpl_valid;
    logic [3:0]                  outst_cnt;
    logic                        busy;
    logic                        err_underflow;

    hbm_cmd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .CLK100(CLK100), .RST100(RST100), .hbm_cal_done(hbm_cal_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .cpl_valid(cpl_valid), .outst_cnt(outst_cnt), .busy(busy),
        .err_underflow(err_underflow)
    );

    always #5 CLK100 = ~CLK100;

    int n_checks = 0;
    int n_err    = 0;

    // Model: a held command (or none), who is next in line, how many are in flight.
    int                 m_next;
    int                 m_cnt;
    bit                 m_hold;
    bit                 m_cal_prev;
    bit                 m_err;
    logic               m_w;
    logic [ADDR_W-1:0]  m_addr;
    logic [LEN_W-1:0]   m_len;
    int                 m_id;
    logic [2:0]         pipe;
    logic [NUM_REQ-1:0] obs_rdy;
    int                 seq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_next = 0; m_cnt = 0; m_hold = 0; m_cal_prev = 0; m_err = 0;
        m_w = 0; m_addr = '0; m_len = '0; m_id = 0; pipe = '0;
    endtask

    task automatic rand_data();
        logic [NUM_REQ*ADDR_W-1:0] a;
        logic [NUM_REQ*LEN_W-1:0]  l;
        a = '0;
        l = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            a = (a << ADDR_W) | (NUM_REQ*ADDR_W)'(ADDR_W'({$urandom(), $urandom()}));
            l = (l << LEN_W) | (NUM_REQ*LEN_W)'(LEN_W'($urandom()));
        end
        req_addr  = a;
        req_len   = l;
        req_write = NUM_REQ'($urandom());
    endtask

    // One clock: compare outputs against the model, then advance the model at the edge.
    task automatic tick();
        logic [NUM_REQ-1:0] exp_rdy;
        logic [NUM_REQ-1:0] tmp;
        bit gnt, acc;
        int w, idx;
        #1;
        gnt = 0;
        w = 0;
        exp_rdy = '0;
        if (!m_hold && m_cal_prev && hbm_cal_done && m_cnt < int'(MAX_OUTST)) begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                idx = (m_next + k) % int'(NUM_REQ);
                tmp = req_valid >> idx;
                if (!gnt && tmp[0]) begin
                    gnt = 1;
                    w = idx;
                end
            end
        end
        if (gnt) exp_rdy = NUM_REQ'(1) << w;
        obs_rdy = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("cmd_valid", 64'(cmd_valid), 64'(m_hold));
        chk("cmd_write", 64'(cmd_write), 64'(m_w));
        chk("cmd_addr", 64'(cmd_addr), 64'(m_addr));
        chk("cmd_len", 64'(cmd_len), 64'(m_len));
        chk("cmd_id", 64'(cmd_id), 64'(m_id));
        chk("outst_cnt", 64'(outst_cnt), 64'(m_cnt));
        chk("busy", 64'(busy), 64'((m_cnt != 0) || m_hold));
        chk("err_underflow", 64'(err_underflow), 64'(m_err));
        acc = m_hold && cmd_ready;
        @(posedge CLK100);
        if (RST100) begin
            model_reset();
        end else begin
            if (acc && !cpl_valid) m_cnt++;
            else if (!acc && cpl_valid) begin
                if (m_cnt == 0) m_err = 1;
                else m_cnt--;
            end
            if (acc) m_hold = 0;
            if (gnt) begin
                m_hold = 1;
                m_id   = w;
                m_w    = 1'(req_write >> w);
                m_addr = ADDR_W'(req_addr >> (w * int'(ADDR_W)));
                m_len  = LEN_W'(req_len >> (w * int'(LEN_W)));
                m_next = (w + 1) % int'(NUM_REQ);
            end
            m_cal_prev = hbm_cal_done;
            pipe = {acc, pipe[2:1]};
        end
        @(negedge CLK100);
    endtask

    task automatic do_reset();
        RST100 = 1'b1;
        model_reset();
        tick();
        RST100 = 1'b0;
    endtask

    initial begin
        RST100 = 1'b1; hbm_cal_done = 1'b0; req_valid = '0; req_write = '0;
        req_addr = '0; req_len = '0; cmd_ready = 1'b0; cpl_valid = 1'b0;
        seq = 0;
        model_reset();
        @(negedge CLK100);
        tick();
        chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("rst_outst", 64'(outst_cnt), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));

        // Calibration gate with everyone requesting.
        RST100 = 1'b0;
        req_valid = '1;
        repeat (20) begin
            tick();
            chk("cal_wait_rdy", 64'(obs_rdy), 64'(0));
        end
        hbm_cal_done = 1'b1;
        tick();
        chk("cal_edge_rdy", 64'(obs_rdy), 64'(0));
        tick();
        chk("first_grant", 64'(obs_rdy), 64'(1));

        // Fair rotation with completions three cycles after each accept.
        do_reset();
        cmd_ready = 1'b1;
        repeat (40) begin
            cpl_valid = pipe[0];
            rand_data();
            tick();
            if (obs_rdy != '0) begin
                chk("rr_seq", 64'(obs_rdy), 64'(1) << (seq % int'(NUM_REQ)));
                seq++;
            end
        end
        cpl_valid = 1'b0;

        // Lone requester 2, then rotation continues from 3.
        do_reset();
        req_valid = '0;
        cmd_ready = 1'b0;
        tick();
        req_valid = 4'b0100;
        req_write = 4'b0100;
        req_addr  = (NUM_REQ*ADDR_W)'(33'h1_0000_0040) << (2 * ADDR_W);
        req_len   = (NUM_REQ*LEN_W)'(4'hF) << (2 * LEN_W);
        tick();
        chk("r2_grant", 64'(obs_rdy), 64'(4'b0100));
        req_valid = '0;
        chk("r2_write", 64'(cmd_write), 64'(1));
        chk("r2_addr", 64'(cmd_addr), 64'(33'h1_0000_0040));
        chk("r2_len", 64'(cmd_len), 64'(15));
        chk("r2_id", 64'(cmd_id), 64'(2));
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        req_valid = 4'b1010;
        tick();
        chk("rr_after_r2", 64'(obs_rdy), 64'(4'b1000));
        req_valid = '0;

        // Saturate at MAX_OUTST, release one, stall, accept with completion.
        do_reset();
        req_valid = '1;
        cmd_ready = 1'b1;
        repeat (30) begin
            rand_data();
            tick();
        end
        chk("sat_cnt", 64'(outst_cnt), 64'(8));
        chk("sat_rdy", 64'(req_ready), 64'(0));
        cpl_valid = 1'b1;
        tick();
        cpl_valid = 1'b0;
        cmd_ready = 1'b0;
        chk("sat_dec", 64'(outst_cnt), 64'(7));
        tick();
        chk("sat_regrant", 64'(obs_rdy), 64'(1));
        repeat (5) tick();
        chk("stall_valid", 64'(cmd_valid), 64'(1));
        cmd_ready = 1'b1;
        cpl_valid = 1'b1;
        tick();
        cpl_valid = 1'b0;
        cmd_ready = 1'b0;
        req_valid = '0;
        chk("acc_cpl_cnt", 64'(outst_cnt), 64'(7));

        // Calibration drops while a command is held.
        req_valid = 4'b0010;
        tick();
        chk("calfall_grant", 64'(obs_rdy), 64'(4'b0010));
        req_valid = '0;
        hbm_cal_done = 1'b0;
        tick();
        tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        hbm_cal_done = 1'b1;
        req_valid = '1;
        tick();
        chk("calfall_nogrant", 64'(obs_rdy), 64'(0));
        chk("calfall_cnt", 64'(outst_cnt), 64'(8));
        req_valid = '0;

        // Completion with nothing in flight.
        do_reset();
        tick();
        cpl_valid = 1'b1;
        tick();
        cpl_valid = 1'b0;
        repeat (3) tick();
        chk("uflow_err", 64'(err_underflow), 64'(1));
        chk("uflow_cnt", 64'(outst_cnt), 64'(0));

        // Asynchronous reset while a command is held.
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        chk("pre_rst_valid", 64'(cmd_valid), 64'(1));
        RST100 = 1'b1;
        #1;
        chk("arst_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_err", 64'(err_underflow), 64'(0));
        chk("arst_cnt", 64'(outst_cnt), 64'(0));
        chk("arst_addr", 64'(cmd_addr), 64'(0));
        chk("arst_id", 64'(cmd_id), 64'(0));
        chk("arst_rdy", 64'(req_ready), 64'(0));
        model_reset();
        tick();
        RST100 = 1'b0;

        // Random traffic.
        repeat (400) begin
            if ($urandom_range(0, 19) == 0) hbm_cal_done = ~hbm_cal_done;
            req_valid = NUM_REQ'($urandom());
            cmd_ready = ($urandom_range(0, 9) < 7);
            cpl_valid = ($urandom_range(0, 4) == 0);
            rand_data();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
